// File: rtl/alarm_set_writer_pkg.sv
// Shared definitions for the alarm programmer and the alarm memory block.
//   - FSM state encoding (3-bit constants, legacy-compatible with the memory side)
//   - Field limits for hour (0..23) and minute (0..59)
//   - Default memory addresses of the alarm hour/minute bytes
//   - Wrap-around up/down stepping helper used by both edit fields
package alarm_set_writer_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_EDIT_HR  = 3'd1;
  localparam logic [2:0] ST_EDIT_MIN = 3'd2;
  localparam logic [2:0] ST_WR_HR    = 3'd3;
  localparam logic [2:0] ST_WR_MIN   = 3'd4;

  localparam logic [7:0] HR_MAX  = 8'd23;
  localparam logic [7:0] MIN_MAX = 8'd59;

  localparam logic [3:0] DEF_ADDR_HR  = 4'h0;
  localparam logic [3:0] DEF_ADDR_MIN = 4'h1;

  // Increment with wrap from max back to 0.
  function automatic logic [7:0] wrap_inc(input logic [7:0] v, input logic [7:0] max);
    return (v >= max) ? 8'd0 : v + 8'd1;
  endfunction

  // Decrement with wrap from 0 up to max.
  function automatic logic [7:0] wrap_dec(input logic [7:0] v, input logic [7:0] max);
    return (v == 8'd0) ? max : v - 8'd1;
  endfunction

  // One edit step: exactly one of up/down moves the field, both or neither hold it.
  function automatic logic [7:0] step_field(input logic [7:0] v, input logic [7:0] max,
                                            input logic up, input logic down);
    logic [7:0] res;
    res = v;
    if (up && !down)      res = wrap_inc(v, max);
    else if (down && !up) res = wrap_dec(v, max);
    return res;
  endfunction

endpackage

// File: rtl/alarm_set_writer_btn_edge.sv
// Rising-edge detector for one front-panel button.
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   i_btn   : button level (already synchronous to i_clk)
//   o_edge  : registered one-cycle pulse, one cycle after the button rises
// A button held high produces exactly one pulse.
module alarm_set_writer_btn_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_edge
);

  logic r_btn_q;
  logic r_edge;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_btn_q <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_btn_q <= i_btn;
      r_edge  <= i_btn & ~r_btn_q;
    end
  end

  assign o_edge = r_edge;

endmodule

// File: rtl/alarm_set_writer.sv
// Button-driven alarm programmer.
// The user edits the alarm hour and minute with Set/Up/Down; after the minute
// is confirmed the block writes the hour byte, then the minute byte, into the
// alarm memory over a req/ack port, and pulses done.
//
// Ports:
//   clk       : system clock, all logic on posedge
//   reset     : asynchronous active-low reset
//   btnSet    : rising edge enters edit mode / advances to the next field
//   btnUp     : rising edge increments the current field
//   btnDown   : rising edge decrements the current field
//   wrAck     : memory accepts the current write (only meaningful while wrReq=1)
//   wrReq     : write request
//   addr      : write address
//   data      : write data (binary)
//   editing   : 1 while the hour or minute is being edited
//   editHr    : hour being edited (0..23)
//   editMin   : minute being edited (0..59)
//   done      : one-cycle pulse after the minute write is acknowledged
//   dbgState  : current FSM state (ST_* encoding) for observation
//
// Write handshake: wrReq rises with addr/data already valid and then holds
// wrReq, addr and data unchanged until wrAck is sampled high on a clock edge
// while wrReq=1; that edge completes the transfer and wrReq drops. wrAck while
// wrReq=0 has no effect.
module alarm_set_writer
  import alarm_set_writer_pkg::*;
#(
  parameter logic [3:0] ADDR_HR     = DEF_ADDR_HR,
  parameter logic [3:0] ADDR_MIN    = DEF_ADDR_MIN,
  parameter int         TIMEOUT_CYC = 1000,
  parameter int         TO_W        = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnSet,
  input  logic       btnUp,
  input  logic       btnDown,
  input  logic       wrAck,
  output logic       wrReq,
  output logic [3:0] addr,
  output logic [7:0] data,
  output logic       editing,
  output logic [7:0] editHr,
  output logic [7:0] editMin,
  output logic       done,
  output logic [2:0] dbgState
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  // Button edges
  logic w_set_e;
  logic w_up_e;
  logic w_dn_e;
  logic w_any_e;

  alarm_set_writer_btn_edge u_set_edge (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_btn   (btnSet),
    .o_edge  (w_set_e)
  );

  alarm_set_writer_btn_edge u_up_edge (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_btn   (btnUp),
    .o_edge  (w_up_e)
  );

  alarm_set_writer_btn_edge u_dn_edge (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_btn   (btnDown),
    .o_edge  (w_dn_e)
  );

  assign w_any_e = w_set_e | w_up_e | w_dn_e;

  // Registered state and outputs
  logic [2:0]      r_state;
  logic [7:0]      r_hr;
  logic [7:0]      r_min;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_req;
  logic [3:0]      r_addr;
  logic [7:0]      r_data;
  logic            r_done;
  logic            r_editing;

  // Next-state values
  logic [2:0]      w_state_nxt;
  logic [7:0]      w_hr_nxt;
  logic [7:0]      w_min_nxt;
  logic [TO_W-1:0] w_to_cnt_nxt;
  logic            w_req_nxt;
  logic [3:0]      w_addr_nxt;
  logic [7:0]      w_data_nxt;
  logic            w_done_nxt;
  logic            w_editing_nxt;

  always_comb begin
    w_state_nxt   = r_state;
    w_hr_nxt      = r_hr;
    w_min_nxt     = r_min;
    w_to_cnt_nxt  = r_to_cnt;
    w_req_nxt     = r_req;
    w_addr_nxt    = r_addr;
    w_data_nxt    = r_data;
    w_done_nxt    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Only Set is honoured here; edited values are kept from last time.
        if (w_set_e) begin
          w_state_nxt  = ST_EDIT_HR;
          w_to_cnt_nxt = '0;
        end
      end

      ST_EDIT_HR: begin
        // Set takes priority over a simultaneous Up/Down: the field is left alone.
        if (w_set_e) begin
          w_state_nxt  = ST_EDIT_MIN;
          w_to_cnt_nxt = '0;
        end else begin
          w_hr_nxt = step_field(r_hr, HR_MAX, w_up_e, w_dn_e);
          if (w_any_e) begin
            w_to_cnt_nxt = '0;
          end else if (r_to_cnt == TO_LAST) begin
            // Inactivity abort: back to idle without writing.
            w_state_nxt  = ST_IDLE;
            w_to_cnt_nxt = '0;
          end else begin
            w_to_cnt_nxt = r_to_cnt + TO_ONE;
          end
        end
      end

      ST_EDIT_MIN: begin
        if (w_set_e) begin
          w_state_nxt  = ST_WR_HR;
          w_to_cnt_nxt = '0;
        end else begin
          w_min_nxt = step_field(r_min, MIN_MAX, w_up_e, w_dn_e);
          if (w_any_e) begin
            w_to_cnt_nxt = '0;
          end else if (r_to_cnt == TO_LAST) begin
            w_state_nxt  = ST_IDLE;
            w_to_cnt_nxt = '0;
          end else begin
            w_to_cnt_nxt = r_to_cnt + TO_ONE;
          end
        end
      end

      ST_WR_HR: begin
        // First cycle in the state loads addr/data and raises the request;
        // afterwards everything holds until the ack.
        if (!r_req) begin
          w_req_nxt  = 1'b1;
          w_addr_nxt = ADDR_HR;
          w_data_nxt = r_hr;
        end else if (wrAck) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = ST_WR_MIN;
        end
      end

      ST_WR_MIN: begin
        if (!r_req) begin
          w_req_nxt  = 1'b1;
          w_addr_nxt = ADDR_MIN;
          w_data_nxt = r_min;
        end else if (wrAck) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase

    w_editing_nxt = (w_state_nxt == ST_EDIT_HR) || (w_state_nxt == ST_EDIT_MIN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_hr      <= 8'd0;
      r_min     <= 8'd0;
      r_to_cnt  <= '0;
      r_req     <= 1'b0;
      r_addr    <= 4'd0;
      r_data    <= 8'd0;
      r_done    <= 1'b0;
      r_editing <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_hr      <= w_hr_nxt;
      r_min     <= w_min_nxt;
      r_to_cnt  <= w_to_cnt_nxt;
      r_req     <= w_req_nxt;
      r_addr    <= w_addr_nxt;
      r_data    <= w_data_nxt;
      r_done    <= w_done_nxt;
      r_editing <= w_editing_nxt;
    end
  end

  assign wrReq    = r_req;
  assign addr     = r_addr;
  assign data     = r_data;
  assign editing  = r_editing;
  assign editHr   = r_hr;
  assign editMin  = r_min;
  assign done     = r_done;
  assign dbgState = r_state;

endmodule

// File: tb/tb_alarm_set_writer.sv
// Directed testbench for alarm_set_writer.
module tb_alarm_set_writer;

  localparam int         TIMEOUT_CYC = 1000;
  localparam logic [3:0] A_HR  = 4'h0;
  localparam logic [3:0] A_MIN = 4'h1;
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_EDIT_HR  = 3'd1;
  localparam logic [2:0] S_EDIT_MIN = 3'd2;
  localparam logic [2:0] S_WR_HR    = 3'd3;
  localparam logic [2:0] S_WR_MIN   = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       btnSet, btnUp, btnDown, wrAck;
  logic       wrReq, editing, done;
  logic [3:0] addr;
  logic [7:0] data, editHr, editMin;
  logic [2:0] dbgState;

  alarm_set_writer #(
    .ADDR_HR     (A_HR),
    .ADDR_MIN    (A_MIN),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btnSet   (btnSet),
    .btnUp    (btnUp),
    .btnDown  (btnDown),
    .wrAck    (wrAck),
    .wrReq    (wrReq),
    .addr     (addr),
    .data     (data),
    .editing  (editing),
    .editHr   (editHr),
    .editMin  (editMin),
    .done     (done),
    .dbgState (dbgState)
  );

  // ---------------- scoreboard ----------------
  int         errors = 0;
  int         checks = 0;
  logic [11:0] exp_q[$];
  logic [7:0] mem_hr  = 8'd0;
  logic [7:0] mem_min = 8'd0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Every accepted write is compared against the expected queue and applied
  // to a small model of the alarm memory.
  always @(posedge clk) begin
    if (reset && wrReq && wrAck) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_write", exp_q.size(), 1);
      end else begin
        check_val("write_addr_data", {addr, data}, exp_q.pop_front());
      end
      if (addr == A_HR) mem_hr = data;
      else              mem_min = data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle button pulse; returns once the FSM has acted on the edge.
  task automatic press(input logic s, input logic u, input logic d);
    btnSet = s; btnUp = u; btnDown = d;
    tick(1);
    btnSet = 1'b0; btnUp = 1'b0; btnDown = 1'b0;
    tick(1);
  endtask

  task automatic press_n(input logic s, input logic u, input logic d, input int n);
    repeat (n) press(s, u, d);
  endtask

  // Wait (bounded) for wrReq, hold off 'delay' cycles, then ack one write.
  task automatic do_ack(input int delay, input logic [3:0] a, input logic [7:0] d);
    int n;
    n = 0;
    exp_q.push_back({a, d});
    while (!wrReq && n < 20) begin
      tick(1);
      n++;
    end
    check_val("ack_wait_req", wrReq, 1);
    if (wrReq) begin
      tick(delay);
      wrAck = 1'b1;
      tick(1);
      wrAck = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bad;
    int n;
    logic saw_req;

    reset = 1'b0; btnSet = 1'b0; btnUp = 1'b0; btnDown = 1'b0; wrAck = 1'b0;
    #3;
    check_val("rst_wrReq", wrReq, 0);
    check_val("rst_state", dbgState, S_IDLE);
    check_val("rst_addr_data", {addr, data}, 0);
    check_val("rst_fields", {editing, done, editHr, editMin}, 0);
    tick(2);
    reset = 1'b1;
    tick(1);

    // ---- basic programming: hour 7, minute 30 ----
    press(1, 0, 0);
    check_val("t2_editing", editing, 1);
    check_val("t2_state_hr", dbgState, S_EDIT_HR);
    press_n(0, 1, 0, 7);
    check_val("t2_hr7", editHr, 7);
    press(1, 0, 0);
    check_val("t2_state_min", dbgState, S_EDIT_MIN);
    press_n(0, 1, 0, 30);
    check_val("t2_min30", editMin, 30);
    check_val("t2_hr_kept", editHr, 7);
    press(1, 0, 0);
    check_val("t2_state_wrhr", dbgState, S_WR_HR);
    check_val("t2_req_late", wrReq, 0);
    tick(1);
    check_val("t2_req_up", wrReq, 1);
    check_val("t2_addr_data_hr", {addr, data}, {A_HR, 8'd7});
    do_ack(3, A_HR, 8'd7);
    do_ack(3, A_MIN, 8'd30);
    check_val("t2_done", done, 1);
    check_val("t2_state_idle", dbgState, S_IDLE);
    check_val("t2_editing_off", editing, 0);
    tick(1);
    check_val("t2_done_pulse", done, 0);
    check_val("t2_mem", {mem_hr, mem_min}, {8'd7, 8'd30});

    // ---- wrap-around on both fields ----
    press(1, 0, 0);
    check_val("t3_values_kept", {editHr, editMin}, {8'd7, 8'd30});
    press_n(0, 0, 1, 7);
    check_val("t3_hr0", editHr, 0);
    press(0, 0, 1);
    check_val("t3_hr_dn_wrap", editHr, 23);
    press(0, 1, 0);
    check_val("t3_hr_up_wrap", editHr, 0);
    press(1, 0, 0);
    press_n(0, 0, 1, 30);
    check_val("t3_min0", editMin, 0);
    press(0, 0, 1);
    check_val("t3_min_dn_wrap", editMin, 59);
    press(0, 1, 0);
    check_val("t3_min_up_wrap", editMin, 0);
    press(1, 0, 0);
    do_ack(1, A_HR, 8'd0);
    do_ack(2, A_MIN, 8'd0);
    check_val("t3_done", done, 1);

    // ---- held button, Up+Down together, Set+Up together ----
    press(1, 0, 0);
    btnUp = 1'b1;
    tick(20);
    btnUp = 1'b0;
    tick(1);
    check_val("t4_held_once", editHr, 1);
    press(0, 1, 1);
    check_val("t4_up_dn_same", editHr, 1);
    press(1, 1, 0);
    check_val("t4_set_wins_state", dbgState, S_EDIT_MIN);
    check_val("t4_set_wins_field", {editHr, editMin}, {8'd1, 8'd0});
    press(1, 0, 0);
    do_ack(1, A_HR, 8'd1);
    do_ack(1, A_MIN, 8'd0);

    // ---- inactivity timeout in EDIT_HR ----
    press(1, 0, 0);
    saw_req = 1'b0;
    repeat (TIMEOUT_CYC - 1) begin
      tick(1);
      if (wrReq) saw_req = 1'b1;
    end
    check_val("t5_still_edit", dbgState, S_EDIT_HR);
    tick(1);
    check_val("t5_timeout_idle", dbgState, S_IDLE);
    check_val("t5_editing_off", editing, 0);
    check_val("t5_no_req", saw_req, 0);
    check_val("t5_hr_kept", editHr, 1);

    // ---- ack withheld: request stable, Set ignored ----
    press_n(1, 0, 0, 3);
    tick(1);
    check_val("t6_req_up", wrReq, 1);
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      press(1, 0, 0);
      if (wrReq !== 1'b1 || addr !== A_HR || data !== 8'd1 || dbgState !== S_WR_HR) bad++;
    end
    check_val("t6_stable", bad, 0);
    do_ack(1, A_HR, 8'd1);
    do_ack(1, A_MIN, 8'd0);
    check_val("t6_done", done, 1);

    // ---- asynchronous reset in WR_HR with request pending ----
    press(1, 0, 0);
    press_n(0, 1, 0, 4);
    press_n(1, 0, 0, 2);
    tick(1);
    check_val("t1_req_before", wrReq, 1);
    #2;
    reset = 1'b0;
    #1;
    check_val("t1_req_async", wrReq, 0);
    check_val("t1_state_async", dbgState, S_IDLE);
    check_val("t1_outs_async", {addr, data, editing, editHr, editMin}, 0);
    tick(1);
    reset = 1'b1;
    tick(1);

    // ---- reset after hour write only: new hour, old minute in memory ----
    press(1, 0, 0);
    press_n(0, 1, 0, 5);
    press(1, 0, 0);
    press_n(0, 1, 0, 3);
    press(1, 0, 0);
    do_ack(1, A_HR, 8'd5);
    n = 0;
    while (!wrReq && n < 20) begin
      tick(1);
      n++;
    end
    check_val("t1b_min_req", {wrReq, addr, data}, {1'b1, A_MIN, 8'd3});
    reset = 1'b0;
    #1;
    check_val("t1b_req_drop", wrReq, 0);
    tick(1);
    reset = 1'b1;
    tick(1);
    check_val("t1b_mem", {mem_hr, mem_min}, {8'd5, 8'd0});

    check_val("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
